// File: rtl/vote_classifier_pkg.sv
// Shared types and default sizing for the spike-vote classifier.
package vote_classifier_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_CLASSES_DEFAULT = 9;
  localparam int COUNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/vote_counter_bank.sv
// One bank of per-class saturating vote counters with an index read/clear port
// and a sticky flag recording that some counter hit its ceiling.
module vote_counter_bank
  import vote_classifier_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int CLASS_WIDTH = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc_en,
  input  logic [CLASS_WIDTH-1:0] inc_idx,
  input  logic                   clr_en,
  input  logic [CLASS_WIDTH-1:0] rd_idx,
  output logic [COUNT_WIDTH-1:0] rd_count,
  input  logic                   sat_clr,
  output logic                   sat
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] cnt_q [NUM_CLASSES];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_CLASSES];
  logic                   sat_q;
  logic                   sat_d;
  logic                   sat_hit;

  assign rd_count = cnt_q[rd_idx];
  assign sat      = sat_q;

  // Next counter values: read-clear wins over increment; a full counter holds.
  always_comb begin
    sat_hit = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_en && (rd_idx == CLASS_WIDTH'(i))) begin
        cnt_d[i] = '0;
      end else if (inc_en && (inc_idx == CLASS_WIDTH'(i))) begin
        if (cnt_q[i] == CNT_MAX) begin
          sat_hit = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    sat_d = sat_clr ? 1'b0 : (sat_q | sat_hit);
  end

  // Counter and sticky flag state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= '0;
      end
      sat_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sat_q <= sat_d;
    end
  end

endmodule

// File: rtl/vote_classifier.sv
// Spike-vote classifier: counts grid output spikes per class into a
// double-buffered counter bank and reports the argmax class per image.
module vote_classifier
  import vote_classifier_pkg::*;
#(
  parameter int NUM_CLASSES  = NUM_CLASSES_DEFAULT,
  parameter int PACKET_WIDTH = 8,
  parameter int COUNT_WIDTH  = COUNT_WIDTH_DEFAULT,
  parameter int CLASS_WIDTH  = $clog2(NUM_CLASSES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] packet_in,
  input  logic                    packet_valid,
  input  logic                    frame_done,
  output logic [CLASS_WIDTH-1:0]  class_out,
  output logic [COUNT_WIDTH-1:0]  max_votes,
  output logic                    class_valid,
  output logic                    no_votes,
  output logic                    saturated,
  output logic                    busy,
  output logic                    frame_overrun
);

  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_CLASSES - 1);

  state_e                   state_q, state_d;
  logic                     bank_sel_q, bank_sel_d;
  logic [CLASS_WIDTH-1:0]   scan_idx_q, scan_idx_d;
  logic [CLASS_WIDTH-1:0]   best_idx_q, best_idx_d;
  logic [COUNT_WIDTH-1:0]   best_cnt_q, best_cnt_d;
  logic [CLASS_WIDTH-1:0]   class_out_q, class_out_d;
  logic [COUNT_WIDTH-1:0]   max_votes_q, max_votes_d;
  logic                     class_valid_q, class_valid_d;
  logic                     no_votes_q, no_votes_d;
  logic                     saturated_q, saturated_d;
  logic                     busy_q, busy_d;
  logic                     frame_overrun_q, frame_overrun_d;

  logic [CLASS_WIDTH-1:0]   pkt_class;
  logic                     scan_bank;
  logic [1:0]               inc_en, clr_en, sat_clr, bank_sat;
  logic [1:0][COUNT_WIDTH-1:0] rd_count;
  logic [COUNT_WIDTH-1:0]   cur_cnt;
  logic                     take;
  logic [COUNT_WIDTH-1:0]   fin_cnt;
  logic [CLASS_WIDTH-1:0]   fin_idx;

  assign pkt_class = CLASS_WIDTH'(packet_in % PACKET_WIDTH'(NUM_CLASSES));
  assign scan_bank = ~bank_sel_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    vote_counter_bank #(
      .NUM_CLASSES (NUM_CLASSES),
      .COUNT_WIDTH (COUNT_WIDTH),
      .CLASS_WIDTH (CLASS_WIDTH)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .inc_en   (inc_en[b]),
      .inc_idx  (pkt_class),
      .clr_en   (clr_en[b]),
      .rd_idx   (scan_idx_q),
      .rd_count (rd_count[b]),
      .sat_clr  (sat_clr[b]),
      .sat      (bank_sat[b])
    );
  end

  // Route increments to the active bank and read/clear to the bank being scanned.
  always_comb begin
    inc_en             = 2'b00;
    clr_en             = 2'b00;
    sat_clr            = 2'b00;
    inc_en[bank_sel_q] = packet_valid;
    clr_en[scan_bank]  = (state_q == SCAN);
    sat_clr[scan_bank] = (state_q == DONE);
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    cur_cnt = rd_count[scan_bank];
    take    = (cur_cnt > best_cnt_q);
    fin_cnt = take ? cur_cnt : best_cnt_q;
    fin_idx = take ? scan_idx_q : best_idx_q;
  end

  // FSM next state and registered-output next values.
  always_comb begin
    state_d         = state_q;
    bank_sel_d      = bank_sel_q;
    scan_idx_d      = scan_idx_q;
    best_idx_d      = best_idx_q;
    best_cnt_d      = best_cnt_q;
    class_out_d     = class_out_q;
    max_votes_d     = max_votes_q;
    no_votes_d      = no_votes_q;
    saturated_d     = saturated_q;
    class_valid_d   = 1'b0;
    frame_overrun_d = frame_done && (state_q != ACCUM);
    case (state_q)
      ACCUM: begin
        if (frame_done) begin
          state_d    = SCAN;
          bank_sel_d = ~bank_sel_q;
          scan_idx_d = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
        end else begin
          state_d = ACCUM;
        end
      end
      SCAN: begin
        best_cnt_d = fin_cnt;
        best_idx_d = fin_idx;
        if (scan_idx_q == LAST_IDX) begin
          state_d       = DONE;
          class_out_d   = fin_idx;
          max_votes_d   = fin_cnt;
          no_votes_d    = (fin_cnt == '0);
          saturated_d   = bank_sat[scan_bank];
          class_valid_d = 1'b1;
        end else begin
          scan_idx_d = scan_idx_q + CLASS_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = ACCUM;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
    busy_d = (state_d != ACCUM);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ACCUM;
      bank_sel_q      <= 1'b0;
      scan_idx_q      <= '0;
      best_idx_q      <= '0;
      best_cnt_q      <= '0;
      class_out_q     <= '0;
      max_votes_q     <= '0;
      class_valid_q   <= 1'b0;
      no_votes_q      <= 1'b0;
      saturated_q     <= 1'b0;
      busy_q          <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bank_sel_q      <= bank_sel_d;
      scan_idx_q      <= scan_idx_d;
      best_idx_q      <= best_idx_d;
      best_cnt_q      <= best_cnt_d;
      class_out_q     <= class_out_d;
      max_votes_q     <= max_votes_d;
      class_valid_q   <= class_valid_d;
      no_votes_q      <= no_votes_d;
      saturated_q     <= saturated_d;
      busy_q          <= busy_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  assign class_out     = class_out_q;
  assign max_votes     = max_votes_q;
  assign class_valid   = class_valid_q;
  assign no_votes      = no_votes_q;
  assign saturated     = saturated_q;
  assign busy          = busy_q;
  assign frame_overrun = frame_overrun_q;

endmodule

// File: doc/vote_classifier.md
Name: vote_classifier

Overview:
- Downstream consumer of the network grid output stream (`packet_out` / `packet_out_valid`).
- Accumulates one vote per output spike into per-class counters, with class = packet value mod NUM_CLASSES.
- On an end-of-image strobe, scans the counters and emits the argmax class with its vote count. This replaces the per-image software vote counting in the bench.
- Two counter banks, so spikes arriving during a scan are counted for the next image and never dropped.

Parameters:
- NUM_CLASSES, 9: number of posture classes; class index = packet % NUM_CLASSES.
- PACKET_WIDTH, 8: width of the grid output packet.
- COUNT_WIDTH, 16: width of each vote counter; counters saturate at the top value.
- CLASS_WIDTH, $clog2(NUM_CLASSES): width of the class index.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- packet_in  in  PACKET_WIDTH  grid output packet.
- packet_valid  in  1  qualifies packet_in; one vote per cycle when high.
- frame_done  in  1  single-cycle pulse; closes the current image.
- class_out  out  CLASS_WIDTH  winning class; held until the next result.
- max_votes  out  COUNT_WIDTH  vote count of the winning class; held.
- class_valid  out  1  one-cycle pulse when class_out / max_votes update.
- no_votes  out  1  held with the result; 1 if every counter of the closed image was 0.
- saturated  out  1  held with the result; 1 if any counter of the closed image saturated.
- busy  out  1  high while the scan is in progress.
- frame_overrun  out  1  one-cycle pulse when frame_done arrives while busy.

Behaviour:
- Reset (rst=0, async): all counters of both banks = 0; active bank = 0; state = ACCUM.
- Reset values of outputs: class_out=0, max_votes=0, class_valid=0, no_votes=0, saturated=0, busy=0, frame_overrun=0.
- Reset asserted mid-scan: the scan is abandoned, no class_valid is produced, and both banks are cleared.
- Class mapping: class = packet_in % NUM_CLASSES, computed combinationally (constant-divisor modulo). Example: packets 3 and 12 both vote for class 3.
- Counting: each cycle with packet_valid=1, the active-bank counter for that class increments by 1.
  - Saturating: a counter at 2^COUNT_WIDTH-1 holds its value and sets the bank's sticky sat flag.
- States:
  - ACCUM: counts into the active bank.
    - frame_done=1 -> SCAN; active bank toggles; the scan index is set to 0.
    - packet_valid in the same cycle as frame_done is counted into the closing (old) bank.
  - SCAN: lasts exactly NUM_CLASSES cycles; in cycle i the scan reads counter[i] of the scan bank.
    - best is updated only when count > best, so ties resolve to the lowest index.
    - counter[i] of the scan bank is cleared to 0 in the same cycle it is read.
    - Counting continues into the new active bank throughout the scan.
    - After the cycle with i = NUM_CLASSES-1 -> DONE.
  - DONE (one cycle):
    - Registers class_out, max_votes, no_votes (best count = 0 gives class 0, no_votes=1) and saturated.
    - Pulses class_valid; clears the scan bank's sat flag; -> ACCUM.
- Latency: frame_done at cycle T gives class_valid high at cycle T+NUM_CLASSES+1 (T+10 with defaults).
- busy = 1 from T+1 through the DONE cycle inclusive.
- frame_done while busy:
  - Ignored: no bank swap, and the in-progress result is unaffected.
  - frame_overrun pulses the next cycle.
  - Votes stay in the active bank and are counted toward the next image.

Decomposition:
- Package vote_classifier_pkg:
  - state enum {ACCUM, SCAN, DONE};
  - default constants NUM_CLASSES_DEFAULT=9 and COUNT_WIDTH_DEFAULT=16.
- Sub-module vote_counter_bank (instantiated twice): NUM_CLASSES saturating counters with a sync increment port, a read/clear-by-index port and a sticky sat flag.
- Top-level logic: FSM, bank select, argmax comparator.

Test Plan:
- Basic argmax: 5x packet 3, 2x packet 12, 4x packet 7, then frame_done at T -> class_valid at T+10, class_out=3, max_votes=7, no_votes=0.
- Tie: 4x packet 2, 4x packet 14 (class 5), frame_done -> class_out=2, max_votes=4.
- Empty image: frame_done with no packets -> class_out=0, max_votes=0, no_votes=1.
- Overlap: image A has 6x class 1, then frame_done; during the scan inject 3x packet 8; after the result, frame_done again -> first result class 1 / 6 votes, second result class 8 / 3 votes.
- Overrun and simultaneity:
  - packet 4 in the same cycle as frame_done counts toward the closing image.
  - A second frame_done 3 cycles later -> frame_overrun pulse, a single class_valid, result unchanged.
- Saturation and reset (COUNT_WIDTH=4):
  - 20x packet 0 -> max_votes=15, saturated=1.
  - rst low during SCAN -> all outputs at reset values, no class_valid.
  - The next frame_done gives no_votes=1.
